all1: RTL and testbench



---
 rtl/all1_pkg.sv | 17 +
 rtl/all1_threshold_neuron.sv | 31 +++
 rtl/all1.sv | 87 ++++++++
 tb/tb_all1.sv | 126 ++++++++++++
 4 files changed

// File: rtl/all1_pkg.sv
// Shared constants and types for the ALL1 two-layer threshold network.
package all1_pkg;

    localparam int WW_DEF = 4;
    localparam int SW_DEF = 6;

    localparam int HID_W  = 1;
    localparam int HID1_B = -1;
    localparam int HID2_B = -2;

    localparam int OUT_W_H1 = 1;
    localparam int OUT_W_H2 = -2;
    localparam int OUT_B    = -1;

    typedef logic signed [SW_DEF-1:0] acc_t;

endpackage

// File: rtl/all1_threshold_neuron.sv
// Combinational step-activation neuron: y = (sum(w_i*x_i) + b >= 0).
module threshold_neuron #(
    parameter int N  = 4,
    parameter int WW = 4,
    parameter int SW = 6,
    parameter logic [N*WW-1:0]    WEIGHTS = '0,
    parameter logic signed [WW-1:0] BIAS  = '0
) (
    input  logic [N-1:0] x,
    output logic         y
);

    function automatic logic signed [SW-1:0] sext(input logic signed [WW-1:0] v);
        return {{(SW-WW){v[WW-1]}}, v};
    endfunction

    logic signed [SW-1:0] acc;

    // Binary inputs reduce each product to a conditional add of the weight.
    always_comb begin
        acc = sext(BIAS);
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                acc = acc + sext(WEIGHTS[i*WW +: WW]);
            end
        end
    end

    assign y = ~acc[SW-1];

endmodule

// File: rtl/all1.sv
// Two-stage pipelined threshold network: out = 1 iff exactly one of x1..x4 is set.
module all1
    import all1_pkg::*;
#(
    parameter int WW = WW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    output logic out,
    output logic out_valid
);

    if (SW < WW + 3) begin : g_bad_sw
        $error("all1: SW must be at least WW+3");
    end

    localparam logic [4*WW-1:0] H_W = {WW'(HID_W), WW'(HID_W), WW'(HID_W), WW'(HID_W)};
    localparam logic [2*WW-1:0] O_W = {WW'(OUT_W_H2), WW'(OUT_W_H1)};

    logic [3:0] x_vec;
    logic       h1_d, h2_d, vld1_d;
    logic       h1_q, h2_q, vld1_q;
    logic       out_d, out_vld_d;
    logic       out_q, out_vld_q;

    assign x_vec = {x4, x3, x2, x1};

    threshold_neuron #(
        .N(4), .WW(WW), .SW(SW), .WEIGHTS(H_W), .BIAS(WW'(HID1_B))
    ) u_h1 (
        .x (x_vec),
        .y (h1_d)
    );

    threshold_neuron #(
        .N(4), .WW(WW), .SW(SW), .WEIGHTS(H_W), .BIAS(WW'(HID2_B))
    ) u_h2 (
        .x (x_vec),
        .y (h2_d)
    );

    threshold_neuron #(
        .N(2), .WW(WW), .SW(SW), .WEIGHTS(O_W), .BIAS(WW'(OUT_B))
    ) u_out (
        .x ({h2_q, h1_q}),
        .y (out_d)
    );

    always_comb begin
        vld1_d    = in_valid;
        out_vld_d = vld1_q;
    end

    // Stage 1: hidden layer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q   <= 1'b0;
            h2_q   <= 1'b0;
            vld1_q <= 1'b0;
        end else begin
            h1_q   <= h1_d;
            h2_q   <= h2_d;
            vld1_q <= vld1_d;
        end
    end

    // Stage 2: output neuron
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_vld_q;

endmodule

// File: tb/tb_all1.sv
// Directed-vector bench for all1: truth table, 2-cycle latency, valid gaps, async reset.
module tb_all1;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic x1, x2, x3, x4;
    logic out;
    logic out_valid;

    int errors = 0;
    int checks = 0;

    logic exp_v1;
    logic exp_o1;

    all1 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .x4        (x4),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, want %b (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Entered at a falling edge; xv is {x1,x2,x3,x4}; e is the hand-computed out for xv.
    task automatic step(input string tag, input logic v, input logic [3:0] xv, input logic e);
        in_valid = v;
        {x1, x2, x3, x4} = xv;
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, out_valid, exp_v1);
        check({tag, ".out"}, out, exp_o1);
        exp_v1 = v;
        exp_o1 = e;
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        {x1, x2, x3, x4} = 4'b0000;
        exp_v1 = 1'b0;
        exp_o1 = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_async.out_valid", out_valid, 1'b0);
        check("rst_async.out", out, 1'b0);

        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom);
            {x1, x2, x3, x4} = 4'($urandom);
            @(posedge clk);
            #1;
            check("rst_hold.out_valid", out_valid, 1'b0);
            check("rst_hold.out", out, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;

        step("onehot0", 1'b1, 4'b0001, 1'b1);
        step("onehot1", 1'b1, 4'b1000, 1'b1);
        step("onehot2", 1'b1, 4'b0010, 1'b1);
        step("onehot3", 1'b1, 4'b0100, 1'b1);

        step("multi0", 1'b1, 4'b0111, 1'b0);
        step("multi1", 1'b1, 4'b0101, 1'b0);
        step("multi2", 1'b1, 4'b0110, 1'b0);
        step("multi3", 1'b1, 4'b1111, 1'b0);

        step("zero", 1'b1, 4'b0000, 1'b0);

        step("ilv0", 1'b1, 4'b0001, 1'b1);
        step("ilv1", 1'b1, 4'b0111, 1'b0);
        step("ilv2", 1'b1, 4'b1000, 1'b1);
        step("ilv3", 1'b1, 4'b0101, 1'b0);
        step("ilv4", 1'b1, 4'b0010, 1'b1);
        step("ilv5", 1'b1, 4'b0110, 1'b0);
        step("ilv6", 1'b1, 4'b0100, 1'b1);

        step("gap0", 1'b1, 4'b1000, 1'b1);
        step("gap1", 1'b0, 4'b0011, 1'b0);
        step("gap2", 1'b1, 4'b0100, 1'b1);
        step("pre_rst", 1'b1, 4'b0001, 1'b1);
        step("pre_rst2", 1'b1, 4'b0010, 1'b1);

        // Pipeline now shows a valid 1 with another valid sample in flight.
        in_valid = 1'b0;
        {x1, x2, x3, x4} = 4'b0000;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst.out_valid", out_valid, 1'b0);
        check("mid_rst.out", out, 1'b0);
        #2 rst_n = 1'b1;
        exp_v1 = 1'b0;
        exp_o1 = 1'b0;
        @(negedge clk);

        step("post_rst0", 1'b0, 4'b0000, 1'b0);
        step("post_rst1", 1'b1, 4'b1000, 1'b1);
        step("post_rst2", 1'b0, 4'b1100, 1'b0);
        step("post_rst3", 1'b0, 4'b0000, 1'b0);
        step("drain", 1'b0, 4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
